// File: rtl/fifo_pkg.sv
// Shared constants and types for the UART 16550 data FIFO.
package fifo_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int TH_W   = 4;

  typedef logic [TH_W-1:0] ptr_t;
  typedef logic [TH_W:0]   cnt_t;

endpackage

// File: rtl/fifo_top.sv
// First-word-fall-through data FIFO (16 x 8) for the UART 16550 block.
// Provides empty/full status, registered underrun/overrun pulses and a
// fill-level trigger against a programmable threshold.
//
// Handshake: push_in/pop_in are requests sampled on the rising edge when en=1.
// A push is accepted when the FIFO is not full, or when a pop is accepted in
// the same cycle. A pop is accepted only when the FIFO is not empty. Rejected
// requests are not retried; they are reported through overrun/underrun on the
// following cycle.
module fifo_top
  import fifo_pkg::*;
(
  input  logic              rst,
  input  logic              clk,
  input  logic              en,
  input  logic              push_in,
  input  logic              pop_in,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              underrun,
  output logic              overrun,
  input  logic [TH_W-1:0]   threshold,
  output logic              thre_trigger
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  ptr_t              rd_ptr_q, rd_ptr_d;
  ptr_t              wr_ptr_q, wr_ptr_d;
  cnt_t              count_q, count_d;
  logic              underrun_q, underrun_d;
  logic              overrun_q, overrun_d;
  logic              do_push;
  logic              do_pop;

  // Status and head data are decoded straight from the registered state.
  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == cnt_t'(DEPTH));
    dout         = mem_q[rd_ptr_q];
    thre_trigger = (count_q >= {1'b0, threshold});
    underrun     = underrun_q;
    overrun      = overrun_q;
  end

  // Qualify requests; a pop frees a slot so a push on a full FIFO still lands.
  always_comb begin
    do_pop  = en & pop_in & ~empty;
    do_push = en & push_in & (~full | do_pop);
  end

  // Next-state for storage, pointers, fill count and error flags.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + ptr_t'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + cnt_t'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - cnt_t'(1);
    end
    underrun_d = en & pop_in & empty;
    overrun_d  = en & push_in & full & ~pop_in;
  end

  // State registers with asynchronous clear of contents and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_fifo_top.sv
// Self-checking bench for fifo_top against a queue-based reference model.
module tb_fifo_top;

  logic       rst;
  logic       clk;
  logic       en;
  logic       push_in;
  logic       pop_in;
  logic [7:0] din;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic       underrun;
  logic       overrun;
  logic [3:0] threshold;
  logic       thre_trigger;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [7:0] exp_q[$];
  logic       exp_under;
  logic       exp_over;

  fifo_top dut (
    .rst          (rst),
    .clk          (clk),
    .en           (en),
    .push_in      (push_in),
    .pop_in       (pop_in),
    .din          (din),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .underrun     (underrun),
    .overrun      (overrun),
    .threshold    (threshold),
    .thre_trigger (thre_trigger)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Compare every observable output against the model.
  task automatic check_outputs(input string ctx);
    check({ctx, ".empty"},    32'(empty),        32'(exp_q.size() == 0));
    check({ctx, ".full"},     32'(full),         32'(exp_q.size() == 16));
    check({ctx, ".underrun"}, 32'(underrun),     32'(exp_under));
    check({ctx, ".overrun"},  32'(overrun),      32'(exp_over));
    check({ctx, ".thre"},     32'(thre_trigger), 32'(exp_q.size() >= int'(threshold)));
    if (exp_q.size() != 0) check({ctx, ".dout"}, 32'(dout), 32'(exp_q[0]));
  endtask

  // Driver: apply one cycle of inputs, advance the model, check after the edge.
  task automatic step(input logic e, input logic p, input logic o, input logic [7:0] d,
                      input string ctx);
    bit was_empty, was_full, acc_pop, acc_push;
    en = e; push_in = p; pop_in = o; din = d;
    was_empty = (exp_q.size() == 0);
    was_full  = (exp_q.size() == 16);
    acc_pop   = e && o && !was_empty;
    acc_push  = e && p && (!was_full || acc_pop);
    exp_under = e && o && was_empty;
    exp_over  = e && p && was_full && !o;
    @(posedge clk);
    #1;
    if (acc_pop) void'(exp_q.pop_front());
    if (acc_push) exp_q.push_back(d);
    check_outputs(ctx);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_under = 1'b0;
    exp_over  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; push_in = 1'b0; pop_in = 1'b0; din = '0; threshold = '0;
    model_reset();

    // 1. Reset held for 5 cycles.
    repeat (5) @(posedge clk);
    #1;
    check("rst.dout", 32'(dout), 32'h0);
    check_outputs("rst");
    rst = 1'b0;

    // 2. Fill past full with threshold 10.
    threshold = 4'hA;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)), "fill");

    // 3. Drain past empty.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 8'h00, "drain");

    // 4. Disabled cycles with both requests asserted.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)), "pre_dis");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'($urandom_range(0, 255)), "dis");
    check("dis.under_low", 32'(underrun), 32'h0);
    check("dis.over_low",  32'(overrun),  32'h0);

    // 5. Full FIFO push+pop, then wrap pointers.
    while (exp_q.size() < 16) step(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)), "refill");
    step(1'b1, 1'b1, 1'b1, 8'h5A, "full_pp");
    check("full_pp.last", 32'(exp_q[15]), 32'h5A);
    for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 1'b1, 8'($urandom_range(0, 255)), "wrap");

    // Random traffic with random threshold and enable.
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) threshold = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), "rand");
    end

    // 6. Asynchronous reset with 7 entries held.
    while (exp_q.size() > 7) step(1'b1, 1'b0, 1'b1, 8'h00, "trim");
    while (exp_q.size() < 7) step(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)), "grow");
    en = 1'b0; push_in = 1'b0; pop_in = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("arst.dout", 32'(dout), 32'h0);
    check_outputs("arst");
    rst = 1'b0;

    // Traffic after reset release.
    for (int i = 0; i < 40; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), "post");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
